blit_uart: RTL and testbench

- Serial line adapter that sits directly upstream and downstream of the blit core's UART byte streams.
- RX deserialises the async line into bytes on a valid/ready stream that drives the core's uart_in_* inputs.
- TX serialises bytes from the core's uart_out_* stream onto the line.
- Format is fixed 8N1, LSB first, idle-high, with a clock-divided bit timer.

---
 rtl/blit_uart_pkg.sv | 32 +++
 rtl/blit_uart_rx.sv | 182 ++++++++++++++++++
 rtl/blit_uart.sv | 163 ++++++++++++++++
 tb/tb_blit_uart.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blit_uart_pkg.sv
// Shared encodings, constants and helpers for the blit UART line adapter.
package blit_uart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    function automatic int div_of(input int hz, input int baud);
        return hz / baud;
    endfunction

    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/blit_uart_rx.sv
// Receive half of blit_uart: synchroniser, mid-bit sampling FSM, one-byte holding register.
// BLIT_UART_PARITY_EN adds an even-parity bit before the stop bit and a parity_err pulse.
module blit_uart_rx
    import blit_uart_pkg::*;
#(
    parameter int DIV = 868
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_ready,
    output logic                 frame_err,
`ifdef BLIT_UART_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 overrun
);

    localparam int              CW       = $clog2(DIV);
    localparam logic [CW-1:0]   FULL     = CW'(DIV - 1);
    localparam logic [CW-1:0]   HALF     = CW'(DIV / 2 - 1);
    localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);

    logic [1:0]           sync_r;
    logic                 rx_s;
    rx_state_t            state_r, state_n;
    logic [CW-1:0]        cnt_r, cnt_n;
    logic [2:0]           bit_r, bit_n;
    logic [DATA_BITS-1:0] shift_r, shift_n;
    logic                 expire_s, deliver_s, ferr_s;
`ifdef BLIT_UART_PARITY_EN
    logic                 par_r, par_n, perr_s;
`endif

    assign rx_s     = sync_r[1];
    assign expire_s = (cnt_r == {CW{1'b0}});

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rx};
        end
    end

    // RX FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= RX_IDLE;
            cnt_r   <= {CW{1'b0}};
            bit_r   <= 3'd0;
            shift_r <= {DATA_BITS{1'b0}};
`ifdef BLIT_UART_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            bit_r   <= bit_n;
            shift_r <= shift_n;
`ifdef BLIT_UART_PARITY_EN
            par_r   <= par_n;
`endif
        end
    end

    // Next-state logic: the half-bit load centres every later sample in its bit cell.
    always_comb begin
        state_n   = state_r;
        cnt_n     = expire_s ? cnt_r : cnt_r - CW'(1);
        bit_n     = bit_r;
        shift_n   = shift_r;
        deliver_s = 1'b0;
        ferr_s    = 1'b0;
`ifdef BLIT_UART_PARITY_EN
        par_n     = par_r;
        perr_s    = 1'b0;
`endif
        case (state_r)
            RX_IDLE: begin
                cnt_n = HALF;
                if (!rx_s) state_n = RX_START;
                else       state_n = RX_IDLE;
            end
            RX_START: begin
                if (expire_s) begin
                    if (rx_s) begin
                        state_n = RX_IDLE;
                    end else begin
                        state_n = RX_DATA;
                        cnt_n   = FULL;
                        bit_n   = 3'd0;
                    end
                end else begin
                    state_n = RX_START;
                end
            end
            RX_DATA: begin
                if (expire_s) begin
                    shift_n = {rx_s, shift_r[DATA_BITS-1:1]};
                    cnt_n   = FULL;
                    bit_n   = bit_r + 3'd1;
`ifdef BLIT_UART_PARITY_EN
                    if (bit_r == LAST_BIT) state_n = RX_PARITY;
`else
                    if (bit_r == LAST_BIT) state_n = RX_STOP;
`endif
                    else                   state_n = RX_DATA;
                end else begin
                    state_n = RX_DATA;
                end
            end
`ifdef BLIT_UART_PARITY_EN
            RX_PARITY: begin
                if (expire_s) begin
                    par_n   = rx_s;
                    cnt_n   = FULL;
                    state_n = RX_STOP;
                end else begin
                    state_n = RX_PARITY;
                end
            end
`endif
            RX_STOP: begin
                if (expire_s) begin
                    if (rx_s == STOP_LEVEL) begin
                        state_n = RX_IDLE;
`ifdef BLIT_UART_PARITY_EN
                        if (par_r != even_parity(shift_r)) perr_s    = 1'b1;
                        else                               deliver_s = 1'b1;
`else
                        deliver_s = 1'b1;
`endif
                    end else begin
                        ferr_s  = 1'b1;
                        state_n = RX_BREAK;
                    end
                end else begin
                    state_n = RX_STOP;
                end
            end
            RX_BREAK: begin
                if (rx_s) state_n = RX_IDLE;
                else      state_n = RX_BREAK;
            end
            default: begin
                state_n = RX_IDLE;
            end
        endcase
    end

    // Holding register: a delivery coinciding with acceptance refills it without overrun.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_valid   <= 1'b0;
            rx_data    <= {DATA_BITS{1'b0}};
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef BLIT_UART_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err  <= ferr_s;
            overrun    <= deliver_s && rx_valid && !rx_ready;
`ifdef BLIT_UART_PARITY_EN
            parity_err <= perr_s;
`endif
            if (deliver_s && (!rx_valid || rx_ready)) begin
                rx_valid <= 1'b1;
                rx_data  <= shift_r;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end else begin
                rx_valid <= rx_valid;
            end
        end
    end

endmodule

// File: rtl/blit_uart.sv
// blit_uart top: 8N1 line adapter for the blit core's byte streams; TX FSM here, RX in blit_uart_rx.
// Defining BLIT_UART_PARITY_EN switches both directions to 8E1 and adds the parity_err port.
module blit_uart
    import blit_uart_pkg::*;
#(
    parameter int HZ   = 100_000_000,
    parameter int BAUD = 115200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic                 tx,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_ready,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 frame_err,
`ifdef BLIT_UART_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 overrun
);

    localparam int            DIV      = div_of(HZ, BAUD);
    localparam int            CW       = $clog2(DIV);
    localparam logic [CW-1:0] FULL     = CW'(DIV - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    if (DIV < 4) begin : g_div_check
        $error("blit_uart: HZ/BAUD must be at least 4");
    end

    tx_state_t            state_r, state_n;
    logic [CW-1:0]        cnt_r, cnt_n;
    logic [2:0]           bit_r, bit_n;
    logic [DATA_BITS-1:0] shift_r, shift_n;
    logic                 tx_n, expire_s;
`ifdef BLIT_UART_PARITY_EN
    logic                 par_r, par_n;
`endif

    assign tx_ready = (state_r == TX_IDLE);
    assign expire_s = (cnt_r == {CW{1'b0}});

    // TX FSM and registered line output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= TX_IDLE;
            cnt_r   <= {CW{1'b0}};
            bit_r   <= 3'd0;
            shift_r <= {DATA_BITS{1'b0}};
            tx      <= STOP_LEVEL;
`ifdef BLIT_UART_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            bit_r   <= bit_n;
            shift_r <= shift_n;
            tx      <= tx_n;
`ifdef BLIT_UART_PARITY_EN
            par_r   <= par_n;
`endif
        end
    end

    // Next-state logic: tx_n is the line level for the following cycle, so each bit spans DIV cycles.
    always_comb begin
        state_n = state_r;
        cnt_n   = expire_s ? cnt_r : cnt_r - CW'(1);
        bit_n   = bit_r;
        shift_n = shift_r;
        tx_n    = tx;
`ifdef BLIT_UART_PARITY_EN
        par_n   = par_r;
`endif
        case (state_r)
            TX_IDLE: begin
                if (tx_valid) begin
                    state_n = TX_START;
                    cnt_n   = FULL;
                    shift_n = tx_data;
                    tx_n    = ~STOP_LEVEL;
`ifdef BLIT_UART_PARITY_EN
                    par_n   = even_parity(tx_data);
`endif
                end else begin
                    state_n = TX_IDLE;
                    tx_n    = STOP_LEVEL;
                end
            end
            TX_START: begin
                if (expire_s) begin
                    state_n = TX_DATA;
                    cnt_n   = FULL;
                    bit_n   = 3'd0;
                    tx_n    = shift_r[0];
                end else begin
                    state_n = TX_START;
                end
            end
            TX_DATA: begin
                if (expire_s) begin
                    cnt_n = FULL;
                    if (bit_r == LAST_BIT) begin
`ifdef BLIT_UART_PARITY_EN
                        state_n = TX_PARITY;
                        tx_n    = par_r;
`else
                        state_n = TX_STOP;
                        tx_n    = STOP_LEVEL;
`endif
                    end else begin
                        state_n = TX_DATA;
                        bit_n   = bit_r + 3'd1;
                        shift_n = {1'b0, shift_r[DATA_BITS-1:1]};
                        tx_n    = shift_r[1];
                    end
                end else begin
                    state_n = TX_DATA;
                end
            end
            TX_PARITY: begin
                if (expire_s) begin
                    state_n = TX_STOP;
                    cnt_n   = FULL;
                    tx_n    = STOP_LEVEL;
                end else begin
                    state_n = TX_PARITY;
                end
            end
            TX_STOP: begin
                tx_n = STOP_LEVEL;
                if (expire_s) state_n = TX_IDLE;
                else          state_n = TX_STOP;
            end
            default: begin
                state_n = TX_IDLE;
                tx_n    = STOP_LEVEL;
            end
        endcase
    end

    blit_uart_rx #(
        .DIV (DIV)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
`ifdef BLIT_UART_PARITY_EN
        .parity_err (parity_err),
`endif
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_blit_uart.sv
// Self-checking bench for blit_uart at DIV=10: TX waveform table, RX scenarios, random RX and loopback.
`timescale 1ns/1ps
module tb_blit_uart;

    localparam int HZ   = 1_000_000;
    localparam int BAUD = 100_000;
    localparam int DIV  = HZ / BAUD;
`ifdef BLIT_UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * DIV;

    typedef struct {
        logic [7:0] data;
        logic [9:0] wave;   // start, d0..d7, stop in time order, MSB first
    } tx_vec_t;

    logic       clk = 1'b0;
    logic       rst_n, rx_drv, rx_line, loop_en;
    logic       tx, rx_valid, rx_ready, tx_valid, tx_ready, frame_err, overrun;
    logic [7:0] rx_data, tx_data;
`ifdef BLIT_UART_PARITY_EN
    logic       parity_err;
    int         n_perr = 0;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_ferr = 0, n_ovr = 0, n_rise = 0, n_vcyc = 0, n_txlow = 0, rise_cyc = 0;
    logic rv_prev = 1'b0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    tx_vec_t    tv[6];
    int         base, f0, o0, r0, v0, c0, d, exp_ferr, to_cnt;
    logic       ok, good;
    logic [7:0] b;

    always #5 clk = ~clk;
    assign rx_line = loop_en ? tx : rx_drv;

    blit_uart #(.HZ(HZ), .BAUD(BAUD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx_line),
        .tx         (tx),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .frame_err  (frame_err),
`ifdef BLIT_UART_PARITY_EN
        .parity_err (parity_err),
`endif
        .overrun    (overrun)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor on the falling edge: pulse counts and accepted bytes.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (frame_err) n_ferr <= n_ferr + 1;
            if (overrun)   n_ovr  <= n_ovr + 1;
`ifdef BLIT_UART_PARITY_EN
            if (parity_err) n_perr <= n_perr + 1;
`endif
            if (!tx)       n_txlow <= n_txlow + 1;
            if (rx_valid)  n_vcyc <= n_vcyc + 1;
            if (rx_valid && !rv_prev) begin
                n_rise   <= n_rise + 1;
                rise_cyc <= cyc;
            end
            if (rx_valid && rx_ready) got.push_back(rx_data);
        end
        rv_prev <= rx_valid;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] byt, input logic stop_bit);
        rx_drv = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rx_drv = byt[i];
            tick(DIV);
        end
`ifdef BLIT_UART_PARITY_EN
        rx_drv = ^byt;
        tick(DIV);
`endif
        rx_drv = stop_bit;
        tick(DIV);
        rx_drv = 1'b1;
    endtask

    task automatic wait_tx_ready(output logic rdy);
        rdy = 1'b0;
        for (int k = 0; k < 3 * FRAME && !rdy; k++) begin
            if (tx_ready) rdy = 1'b1;
            else          tick();
        end
    endtask

    // Expected line level during bit cell k of a frame carrying v.data.
    function automatic logic exp_bit(input tx_vec_t v, input int k);
        if (k < 9) return v.wave[9 - k];
`ifdef BLIT_UART_PARITY_EN
        if (k == 9) return ^v.data;
`endif
        return v.wave[0];
    endfunction

    initial begin
        tv[0] = '{data: 8'hA5, wave: 10'b0101001011};
        tv[1] = '{data: 8'h3C, wave: 10'b0001111001};
        tv[2] = '{data: 8'h00, wave: 10'b0000000001};
        tv[3] = '{data: 8'hFF, wave: 10'b0111111111};
        tv[4] = '{data: 8'h80, wave: 10'b0000000011};
        tv[5] = '{data: 8'h01, wave: 10'b0100000001};

        rst_n = 1'b0; rx_drv = 1'b1; loop_en = 1'b0;
        rx_ready = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        tick(3);
        check("reset_tx", tx, 1);
        check("reset_tx_ready", tx_ready, 1);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        rst_n = 1'b1;
        tick(200);
        check("idle_tx_low_cycles", n_txlow, 0);
        check("idle_pulses", n_ferr + n_ovr + n_rise, 0);

        // TX waveform table; tx_data is scrambled after acceptance to prove it was latched.
        for (int v = 0; v < 6; v++) begin
            wait_tx_ready(ok);
            check("tx_ready_wait", ok, 1);
            tx_data = tv[v].data; tx_valid = 1'b1;
            tick();
            tx_valid = 1'b0; tx_data = ~tv[v].data;
            for (int j = 0; j < FRAME; j++) begin
                check($sformatf("tx_bit v%0d cyc%0d", v, j), tx, exp_bit(tv[v], j / DIV));
                if (j == 0 || j == FRAME - 1) check("tx_ready_busy", tx_ready, 0);
                tick();
            end
            check("tx_ready_after_frame", tx_ready, 1);
            check("tx_idle_after_frame", tx, 1);
        end

        // Back-to-back: 3C held valid starts one cycle after tx_ready rises.
        tx_data = tv[0].data; tx_valid = 1'b1;
        tick();
        tx_data = tv[1].data;
        for (int j = 0; j < FRAME; j++) begin
            check("b2b_first_bit", tx, exp_bit(tv[0], j / DIV));
            tick();
        end
        check("b2b_ready_rise", tx_ready, 1);
        check("b2b_gap_high", tx, 1);
        tick();
        tx_valid = 1'b0;
        check("b2b_second_start", tx, 0);
        check("b2b_second_busy", tx_ready, 0);
        for (int j = 1; j < FRAME; j++) begin
            tick();
            check("b2b_second_bit", tx, exp_bit(tv[1], j / DIV));
        end
        tick();
        check("b2b_ready_end", tx_ready, 1);

        // Reset in the middle of TX and RX frames.
        base = got.size(); f0 = n_ferr;
        tx_data = 8'h00; tx_valid = 1'b1; rx_drv = 1'b0;
        tick();
        tx_valid = 1'b0;
        tick(30);
        rst_n = 1'b0;
        tick();
        check("abort_tx_high", tx, 1);
        check("abort_tx_ready", tx_ready, 1);
        rx_drv = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(FRAME + 20);
        check("abort_rx_no_byte", got.size() - base, 0);
        check("abort_rx_no_ferr", n_ferr - f0, 0);
        check("abort_tx_stays_high", tx, 1);

        // Single RX frame: one-cycle rx_valid, close to the middle of the stop bit.
        base = got.size(); r0 = n_rise; v0 = n_vcyc; f0 = n_ferr;
        rx_ready = 1'b1;
        c0 = cyc;
        send_rx(8'h4B, 1'b1);
        tick(5);
        d = rise_cyc - c0;
        check("rx_count", got.size() - base, 1);
        if (got.size() > base) check("rx_data_4b", got[base], 8'h4B);
        check("rx_valid_rises", n_rise - r0, 1);
        check("rx_valid_one_cycle", n_vcyc - v0, 1);
        check("rx_latency", (d >= (NBITS - 1) * DIV + DIV / 2) && (d <= (NBITS - 1) * DIV + DIV / 2 + 3), 1);

        // Short glitch must not start a byte.
        base = got.size(); f0 = n_ferr;
        rx_drv = 1'b0;
        tick(3);
        rx_drv = 1'b1;
        tick(FRAME + 20);
        check("glitch_no_byte", got.size() - base, 0);
        check("glitch_no_ferr", n_ferr - f0, 0);

        // Backpressure: second byte is dropped with a single overrun.
        base = got.size(); o0 = n_ovr;
        rx_ready = 1'b0;
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        tick(5);
        check("bp_valid_held", rx_valid, 1);
        check("bp_data_held", rx_data, 8'h11);
        check("bp_overrun_once", n_ovr - o0, 1);
        rx_ready = 1'b1;
        tick();
        check("bp_valid_falls", rx_valid, 0);
        check("bp_accepted_count", got.size() - base, 1);
        if (got.size() > base) check("bp_accepted_11", got[base], 8'h11);

        // Framing error followed by a break, then a clean byte.
        base = got.size(); f0 = n_ferr;
        send_rx(8'hFF, 1'b0);
        rx_drv = 1'b0;
        tick(50);
        rx_drv = 1'b1;
        tick(20);
        send_rx(8'h33, 1'b1);
        tick(5);
        check("ferr_once", n_ferr - f0, 1);
        check("ferr_then_one_byte", got.size() - base, 1);
        if (got.size() > base) check("ferr_then_33", got[base], 8'h33);

        // Random RX frames against a byte-level model: bad-stop frames only count as frame errors.
        base = got.size(); f0 = n_ferr; o0 = n_ovr; exp_ferr = 0;
        exp_q.delete();
        for (int n = 0; n < 60; n++) begin
            b = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 7) != 0);
            send_rx(b, good);
            if (good) exp_q.push_back(b);
            else      exp_ferr++;
            tick(good ? $urandom_range(0, 15) : $urandom_range(3, 15));
        end
        tick(5);
        check("rand_rx_count", got.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < got.size(); i++)
            check($sformatf("rand_rx_byte %0d", i), got[base + i], exp_q[i]);
        check("rand_rx_ferr", n_ferr - f0, exp_ferr);
        check("rand_rx_overrun", n_ovr - o0, 0);

        // Loopback: 00..FF then random bytes, streamed back to back.
        loop_en = 1'b1; rx_ready = 1'b1;
        base = got.size(); f0 = n_ferr; o0 = n_ovr; to_cnt = 0;
`ifdef BLIT_UART_PARITY_EN
        r0 = n_perr;
`endif
        exp_q.delete();
        for (int n = 0; n < 276; n++) begin
            b = (n < 256) ? 8'(n) : 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            tx_data = b; tx_valid = 1'b1;
            wait_tx_ready(ok);
            if (!ok) to_cnt++;
            tick();
        end
        tx_valid = 1'b0;
        tick(FRAME + 30);
        check("loop_no_timeout", to_cnt, 0);
        check("loop_count", got.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < got.size(); i++)
            if (got[base + i] !== exp_q[i]) check($sformatf("loop_byte %0d", i), got[base + i], exp_q[i]);
        check("loop_in_order", (got.size() - base == exp_q.size()) && (got[base] == 8'h00) && (got[base + 255] == 8'hFF), 1);
        check("loop_no_ferr", n_ferr - f0, 0);
        check("loop_no_overrun", n_ovr - o0, 0);
`ifdef BLIT_UART_PARITY_EN
        check("loop_no_perr", n_perr - r0, 0);
`endif
        loop_en = 1'b0;
        tick(5);

`ifdef BLIT_UART_PARITY_EN
        // Flipped parity on 55 is dropped with one parity_err; a correct 55 follows.
        base = got.size(); r0 = n_perr; f0 = n_ferr;
        rx_drv = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[0] ^ b[0] ^ ((8'h55 >> i) & 8'h01) != 8'h00;
            tick(DIV);
        end
        rx_drv = ~(^8'h55);
        tick(DIV);
        rx_drv = 1'b1;
        tick(DIV + 10);
        check("par_err_once", n_perr - r0, 1);
        check("par_byte_dropped", got.size() - base, 0);
        check("par_no_ferr", n_ferr - f0, 0);
        send_rx(8'h55, 1'b1);
        tick(5);
        check("par_good_count", got.size() - base, 1);
        if (got.size() > base) check("par_good_55", got[base], 8'h55);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
